pipe_skid_stage: RTL and testbench

//   Generic pipeline stage register replacing fixed per-stage register banks (IF/ID, ID/EX, EX/MEM).

---
 rtl/pipe_skid_stage.sv | 89 ++++++++
 tb/tb_pipe_skid_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush_i             drop held entries and any same-cycle incoming payload
//   up_valid_i/_ready_o upstream handshake, up_data_i payload in
//   dn_valid_o/_ready_i downstream handshake, dn_data_o payload out (straight from a flop)
//   cnt_clr_i           clear of stall_cnt_o (wins over increment)
//   stall_cnt_o         saturating count of cycles with dn_valid_o & ~dn_ready_i
module pipe_skid_stage #(
    parameter int              DW      = 64,
    parameter bit              SKID_EN = 1'b1,
    parameter logic [DW-1:0]   RST_VAL = '0,
    parameter int              CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          up_valid_i,
    output logic          up_ready_o,
    input  logic [DW-1:0] up_data_i,
    output logic          dn_valid_o,
    input  logic          dn_ready_i,
    output logic [DW-1:0] dn_data_o,
    input  logic          cnt_clr_i,
    output logic [CW-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    state_t        state_q;
    logic [DW-1:0] main_q, skid_q;
    logic          valid_q, rdy_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          up_in, dn_out;
    // With the skid buffer the ready is a flop, cutting the dn_ready_i -> up_ready_o path.
    assign up_ready_o  = SKID_EN ? rdy_q : (~valid_q | dn_ready_i);
    assign up_in       = up_valid_i & up_ready_o;
    assign dn_out      = valid_q & dn_ready_i;
    assign dn_valid_o  = valid_q;
    assign dn_data_o   = main_q;
    assign stall_cnt_o = cnt_q;
    always_comb begin
        cnt_d = cnt_clr_i ? '0 : (valid_q & ~dn_ready_i & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
                state_q <= EMPTY;
                valid_q <= 1'b0;
                rdy_q   <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: if (up_in) begin
                        main_q  <= up_data_i;
                        state_q <= FULL;
                        valid_q <= 1'b1;
                    end
                    FULL: if (up_in && dn_out) begin
                        main_q <= up_data_i;
                    end else if (dn_out) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end else if (up_in && SKID_EN) begin
                        // Downstream stalled while the registered ready still said yes: park it.
                        skid_q  <= up_data_i;
                        state_q <= SKID;
                        rdy_q   <= 1'b0;
                    end
                    SKID: if (dn_out) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                        rdy_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: checks a skid instance (CW=4) and a no-skid instance (CW=6) side by side.
module tb_pipe_skid_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fl = 1'b0, up_v = 1'b0, dn_r = 1'b0, cl = 1'b0;
    logic [15:0] up_d = '0;
    logic        a_r, a_v, b_r, b_v;
    logic [15:0] a_d, b_d;
    logic [3:0]  a_c;
    logic [5:0]  b_c;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DW(16), .SKID_EN(1'b1), .RST_VAL(16'hBEEF), .CW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(fl), .up_valid_i(up_v), .up_ready_o(a_r),
        .up_data_i(up_d), .dn_valid_o(a_v), .dn_ready_i(dn_r), .dn_data_o(a_d),
        .cnt_clr_i(cl), .stall_cnt_o(a_c));
    pipe_skid_stage #(.DW(16), .SKID_EN(1'b0), .RST_VAL(16'h1234), .CW(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(fl), .up_valid_i(up_v), .up_ready_o(b_r),
        .up_data_i(up_d), .dn_valid_o(b_v), .dn_ready_i(dn_r), .dn_data_o(b_d),
        .cnt_clr_i(cl), .stall_cnt_o(b_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        uv;
        logic [15:0] ud;
        logic        dr, fl, cl;
        logic        ev;
        logic [15:0] ed;
        logic        er;
        logic [3:0]  ec;
    } vec_t;
    vec_t tbl [19];

    logic [15:0] qa[$], qb[$];
    int          ca, cb, deliv_b;
    logic        ea_r, eb_r, sa, sb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // uv  ud        dr    fl    cl    ev    ed        er    ec
        tbl[0]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 4'd0};
        tbl[2]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd1};
        tbl[3]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd2};
        tbl[4]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd3};
        tbl[5]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000B, 1'b1, 4'd3};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000C, 1'b1, 4'd3};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3};
        tbl[8]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3};
        tbl[9]  = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 4'd3};
        tbl[10] = '{1'b1, 16'h0044, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 4'd4};
        tbl[11] = '{1'b1, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd5};
        tbl[12] = '{1'b1, 16'h0066, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0055, 1'b1, 4'd5};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd6};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0};
        tbl[15] = '{1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0077, 1'b1, 4'd0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b1, 4'd0};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0};

        // Power-on reset state
        repeat (2) @(negedge clk);
        chk("rst_a_valid", 32'(a_v), 0);
        chk("rst_a_data", 32'(a_d), 32'hBEEF);
        chk("rst_a_ready", 32'(a_r), 1);
        chk("rst_a_cnt", 32'(a_c), 0);
        chk("rst_b_data", 32'(b_d), 32'h1234);
        chk("rst_b_ready", 32'(b_r), 1);
        rst_n = 1'b1;

        // Streaming 1..8 back-to-back with downstream always ready
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            up_v = (i < 8);
            up_d = 16'(i + 1);
            dn_r = 1'b1;
            #1;
            chk("stream_a_ready", 32'(a_r), 1);
            chk("stream_a_valid", 32'(a_v), 32'(i > 0));
            chk("stream_b_valid", 32'(b_v), 32'(i > 0));
            if (i > 0) begin
                chk("stream_a_data", 32'(a_d), 32'(i));
                chk("stream_b_data", 32'(b_d), 32'(i));
            end
        end

        // Back-pressure, skid, flush and counter-clear vectors on the skid instance
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            up_v = tbl[i].uv;
            up_d = tbl[i].ud;
            dn_r = tbl[i].dr;
            fl   = tbl[i].fl;
            cl   = tbl[i].cl;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(a_v), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 32'(a_d), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_ready", i), 32'(a_r), 32'(tbl[i].er));
            chk($sformatf("vec%0d_cnt", i), 32'(a_c), 32'(tbl[i].ec));
        end

        // Saturation: empty both, load one item, stall 20 cycles
        @(negedge clk);
        up_v = 1'b0; dn_r = 1'b0; fl = 1'b1; cl = 1'b1;
        @(negedge clk);
        fl = 1'b0; cl = 1'b0; up_v = 1'b1; up_d = 16'h005A;
        repeat (20) begin
            @(negedge clk);
            up_v = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("sat_a_cnt", 32'(a_c), 15);
        chk("sat_b_cnt", 32'(b_c), 20);
        chk("sat_a_hold", 32'(a_d), 32'h005A);
        chk("sat_b_ready", 32'(b_r), 0);
        cl = 1'b1;
        @(negedge clk);
        cl = 1'b0;
        #1;
        chk("clr_a_cnt", 32'(a_c), 0);
        chk("clr_b_cnt", 32'(b_c), 0);

        // Asynchronous reset in the middle of a stalled stream
        up_v = 1'b1; up_d = 16'h00C3;
        @(negedge clk);
        up_v = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_a_ready", 32'(a_r), 0);
        chk("pre_rst_a_cnt", 32'(a_c), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(a_v), 0);
        chk("mid_rst_a_data", 32'(a_d), 32'hBEEF);
        chk("mid_rst_a_ready", 32'(a_r), 1);
        chk("mid_rst_a_cnt", 32'(a_c), 0);
        chk("mid_rst_b_valid", 32'(b_v), 0);
        chk("mid_rst_b_data", 32'(b_d), 32'h1234);
        chk("mid_rst_b_cnt", 32'(b_c), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against a queue model of each stage
        ca = 0; cb = 0; deliv_b = 0;
        for (int cyc = 0; cyc < 20000 && deliv_b < 1000; cyc++) begin
            @(negedge clk);
            up_v = ($urandom_range(0, 3) != 0);
            up_d = 16'($urandom);
            dn_r = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 63) == 0);
            cl   = ($urandom_range(0, 63) == 0);
            #1;
            ea_r = (qa.size() < 2);
            eb_r = (qb.size() == 0) || dn_r;
            chk("rnd_a_valid", 32'(a_v), 32'(qa.size() > 0));
            if (qa.size() > 0) chk("rnd_a_data", 32'(a_d), 32'(qa[0]));
            chk("rnd_a_ready", 32'(a_r), 32'(ea_r));
            chk("rnd_a_cnt", 32'(a_c), 32'(ca));
            chk("rnd_b_valid", 32'(b_v), 32'(qb.size() > 0));
            if (qb.size() > 0) chk("rnd_b_data", 32'(b_d), 32'(qb[0]));
            chk("rnd_b_ready", 32'(b_r), 32'(eb_r));
            chk("rnd_b_cnt", 32'(b_c), 32'(cb));
            sa = (qa.size() > 0) && !dn_r;
            sb = (qb.size() > 0) && !dn_r;
            if (qb.size() > 0 && dn_r) deliv_b++;
            if (fl) begin
                qa.delete();
                qb.delete();
            end else begin
                if (qa.size() > 0 && dn_r) void'(qa.pop_front());
                if (up_v && ea_r) qa.push_back(up_d);
                if (qb.size() > 0 && dn_r) void'(qb.pop_front());
                if (up_v && eb_r) qb.push_back(up_d);
            end
            ca = cl ? 0 : (sa && ca < 15) ? ca + 1 : ca;
            cb = cl ? 0 : (sb && cb < 63) ? cb + 1 : cb;
        end
        chk("rnd_b_delivered_1000", 32'(deliv_b >= 1000), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
